// File: rtl/grass_pkg.sv
// grass_pkg: shared constants and types for the grass tile ROM and the
// read-side engine that feeds it.
//   TILE_W / TILE_H : tile geometry in pixels (row-major ROM layout)
//   ROM_DEPTH       : number of ROM words (TILE_W*TILE_H)
//   ADDR_W          : ROM address width
//   COL_W           : width of column / scroll values (0..TILE_W-1)
//   TRANSP          : colour key treated as transparent
package grass_pkg;

  localparam int unsigned TILE_W    = 20;
  localparam int unsigned TILE_H    = 20;
  localparam int unsigned ROM_DEPTH = TILE_W * TILE_H;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned COL_W     = 5;
  localparam logic [7:0]  TRANSP    = 8'h00;

  typedef logic [ADDR_W-1:0] rom_addr_t;
  typedef logic [COL_W-1:0]  col_t;

  // a + b modulo m, valid while both operands are already below m.
  function automatic col_t wrap_add(input col_t a, input col_t b,
                                    input int unsigned m);
    int unsigned s;
    s = 32'(a) + 32'(b);
    if (s >= m) s = s - m;
    return col_t'(s);
  endfunction

endpackage

// File: rtl/grass_scroll_ctr.sv
// grass_scroll_ctr: modulo-MOD accumulator advancing by STEP when en is high.
//   clk     in  clock
//   rst     in  synchronous active-high reset (value -> 0)
//   en      in  advance by STEP this cycle
//   val     out registered accumulator value
//   val_nxt out value val will take after this edge (lets the caller use the
//               freshly advanced value in the same cycle as en)
module grass_scroll_ctr
  import grass_pkg::*;
#(
  parameter int unsigned MOD  = 20,
  parameter int unsigned STEP = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output col_t val,
  output col_t val_nxt
);

  always_comb begin
    val_nxt = val;
    if (en) val_nxt = wrap_add(val, col_t'(STEP), MOD);
  end

  always_ff @(posedge clk) begin
    if (rst) val <= '0;
    else     val <= val_nxt;
  end

endmodule

// File: rtl/grass_fetch.sv
// grass_fetch: read-side engine for the grass tile ROM. Maps the VGA pixel
// stream onto ROM addresses for a horizontally scrolling ground strip and
// re-aligns the ROM colour with the pixel stream.
//   clka        in  pixel clock
//   rsta        in  synchronous active-high reset
//   pix_x       in  current column (debug only, not used by the datapath)
//   pix_y       in  current row
//   pix_de      in  active-video enable
//   frame_start in  one-cycle frame pulse
//   run         in  scroll advances on frame_start only while high
//   rom_addr    out registered ROM address
//   rom_data    in  ROM read data (one cycle after rom_addr)
//   pix_out     out strip colour, 0 outside the strip
//   pix_out_de  out pix_de aligned with pix_out
//   pix_opaque  out pixel is in the strip and not the transparent key
//   scroll      out current scroll offset
module grass_fetch #(
  parameter int unsigned TILE_W      = 20,
  parameter int unsigned TILE_H      = 20,
  parameter int unsigned STRIP_Y0    = 400,
  parameter int unsigned SCROLL_STEP = 2,
  parameter logic [7:0]  TRANSP      = 8'h00
) (
  input  logic                         clka,
  input  logic                         rsta,
  input  logic [9:0]                   pix_x,
  input  logic [9:0]                   pix_y,
  input  logic                         pix_de,
  input  logic                         frame_start,
  input  logic                         run,
  output logic [grass_pkg::ADDR_W-1:0] rom_addr,
  input  logic [7:0]                   rom_data,
  output logic [7:0]                   pix_out,
  output logic                         pix_out_de,
  output logic                         pix_opaque,
  output logic [4:0]                   scroll
);
  import grass_pkg::*;

  if (TILE_W * TILE_H > (1 << ADDR_W)) begin : g_bad_size
    $error("grass_fetch: TILE_W*TILE_H exceeds the ROM address space");
  end
  if (TILE_W > (1 << COL_W)) begin : g_bad_width
    $error("grass_fetch: TILE_W does not fit the column counter");
  end
  if (SCROLL_STEP < 1 || SCROLL_STEP >= TILE_W) begin : g_bad_step
    $error("grass_fetch: SCROLL_STEP must be in 1..TILE_W-1");
  end

  localparam rom_addr_t  ROW_STEP = rom_addr_t'(TILE_W);
  localparam rom_addr_t  ROW_MAX  = rom_addr_t'((TILE_H - 1) * TILE_W);
  localparam logic [9:0] Y_LO     = 10'(STRIP_Y0);
  localparam logic [9:0] Y_HI     = 10'(STRIP_Y0 + TILE_H);

  // pix_x is kept on the port for debug compare; fold it into a sink.
  logic unused_pix_x;
  assign unused_pix_x = ^pix_x;

  col_t      scroll_q;
  col_t      scroll_nxt;
  col_t      col;
  col_t      col_eff;
  col_t      col_inc;
  rom_addr_t row_base;
  rom_addr_t row_base_eff;
  rom_addr_t addr_nxt;
  logic      in_strip;
  logic      de_d;
  logic      de_d2;
  logic      strip_d1;
  logic      strip_d2;
  logic      line_end;

  grass_scroll_ctr #(
    .MOD  (TILE_W),
    .STEP (SCROLL_STEP)
  ) u_scroll (
    .clk     (clka),
    .rst     (rsta),
    .en      (frame_start & run),
    .val     (scroll_q),
    .val_nxt (scroll_nxt)
  );

  assign scroll = scroll_q;

  // frame_start takes effect before the pixel of the same cycle: the first
  // pixel sees the advanced scroll and a cleared row base.
  always_comb begin
    in_strip     = pix_de && (pix_y >= Y_LO) && (pix_y < Y_HI);
    row_base_eff = frame_start ? '0 : row_base;
    col_eff      = (pix_de && !de_d) ? scroll_nxt : col;
    col_inc      = wrap_add(col_eff, col_t'(1), TILE_W);
    addr_nxt     = in_strip ? (row_base_eff + rom_addr_t'(col_eff)) : '0;
    // strip_d1 still holds the last active pixel's membership here.
    line_end     = de_d && !pix_de && strip_d1;
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      col      <= '0;
      row_base <= '0;
      de_d     <= 1'b0;
      de_d2    <= 1'b0;
      strip_d1 <= 1'b0;
      strip_d2 <= 1'b0;
      rom_addr <= '0;
    end else begin
      de_d     <= pix_de;
      de_d2    <= de_d;
      strip_d1 <= in_strip;
      strip_d2 <= strip_d1;
      rom_addr <= addr_nxt;
      if (pix_de) col <= col_inc;
      if (frame_start) begin
        row_base <= '0;
      end else if (line_end) begin
        row_base <= (row_base >= ROW_MAX) ? ROW_MAX : (row_base + ROW_STEP);
      end
    end
  end

  // Output stage: the ROM has no output register, so rom_data for the pixel
  // sampled two edges ago is present now.
  always_ff @(posedge clka) begin
    if (rsta) begin
      pix_out    <= '0;
      pix_out_de <= 1'b0;
      pix_opaque <= 1'b0;
    end else begin
      pix_out    <= strip_d2 ? rom_data : '0;
      pix_out_de <= de_d2;
      pix_opaque <= strip_d2 && (rom_data != TRANSP);
    end
  end

endmodule

// File: tb/tb_grass_fetch.sv
module tb_grass_fetch;

  localparam int TW   = 20;
  localparam int TH   = 20;
  localparam int Y0   = 400;
  localparam int STEP = 2;
  localparam logic [7:0] TR = 8'h00;
  localparam int MAXC = 16384;

  logic       clka = 1'b0;
  logic       rsta;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_de;
  logic       frame_start;
  logic       run;
  logic [8:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] pix_out;
  logic       pix_out_de;
  logic       pix_opaque;
  logic [4:0] scroll;

  always #5 clka = ~clka;

  grass_fetch #(
    .TILE_W      (TW),
    .TILE_H      (TH),
    .STRIP_Y0    (Y0),
    .SCROLL_STEP (STEP),
    .TRANSP      (TR)
  ) dut (
    .clka        (clka),
    .rsta        (rsta),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_de      (pix_de),
    .frame_start (frame_start),
    .run         (run),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pix_out     (pix_out),
    .pix_out_de  (pix_out_de),
    .pix_opaque  (pix_opaque),
    .scroll      (scroll)
  );

  // Synchronous ROM, no output register.
  logic [7:0] rom [0:511];
  always @(posedge clka) rom_data <= rom[rom_addr];

  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] pix;
    logic       de;
    logic       opq;
    logic [4:0] scr;
  } smp_t;

  smp_t q_obs[$];
  smp_t q_exp[$];

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model state: scroll value, count of strip lines finished since
  // frame_start, and the current line's start scroll / pixel index.
  int m_scroll, m_rows, m_s0, m_n, cyc;
  bit m_prev_de, m_prev_strip;
  int h_addr [MAXC];
  bit h_strip[MAXC];
  bit h_de   [MAXC];

  task automatic tick(input bit rst, input bit fs, input bit rn,
                      input bit de, input int y);
    int c, col, row;
    bit ins;
    smp_t e;
    c = cyc;
    rsta = rst; frame_start = fs; run = rn; pix_de = de;
    pix_y = 10'(y); pix_x = 10'($urandom_range(0, 799));
    if (rst) begin
      m_scroll = 0; m_rows = 0; m_s0 = 0; m_n = 0;
      m_prev_de = 0; m_prev_strip = 0;
      h_addr[c] = 0; h_strip[c] = 0; h_de[c] = 0;
      if (c >= 1) begin h_strip[c-1] = 0; h_de[c-1] = 0; end
      if (c >= 2) begin h_strip[c-2] = 0; h_de[c-2] = 0; end
    end else begin
      if (fs) begin
        if (rn) m_scroll = (m_scroll + STEP) % TW;
        m_rows = 0;
      end else if (m_prev_de && !de && m_prev_strip) begin
        m_rows++;
      end
      ins = de && (y >= Y0) && (y < Y0 + TH);
      col = 0;
      if (de) begin
        if (!m_prev_de) begin m_s0 = m_scroll; m_n = 0; end
        col = (m_s0 + m_n) % TW;
        m_n++;
      end
      row = (m_rows < TH - 1) ? m_rows : TH - 1;
      h_addr[c]  = ins ? row * TW + col : 0;
      h_strip[c] = ins;
      h_de[c]    = de;
      m_prev_de = de; m_prev_strip = ins;
    end
    e.addr = 9'(h_addr[c]);
    e.scr  = 5'(m_scroll);
    e.pix = '0; e.de = 1'b0; e.opq = 1'b0;
    if (c >= 2) begin
      e.de = h_de[c-2];
      if (h_strip[c-2]) begin
        e.pix = rom[h_addr[c-2]];
        e.opq = (rom[h_addr[c-2]] != TR);
      end
    end
    @(posedge clka);
    #1;
    cyc++;
    q_exp.push_back(e);
    q_obs.push_back('{rom_addr, pix_out, pix_out_de, pix_opaque, scroll});
  endtask

  task automatic px(input int y, input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 1, y);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    q_obs.delete(); q_exp.delete();
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 1, 1, 400);
    tick(1, 0, 0, 1, 401);
    for (int i = 0; i < q_obs.size(); i++) begin
      tests++;
      if (q_obs[i] !== smp_t'(0)) begin
        fails++;
        $display("FAIL reset_outputs i=%0d got=%h exp=0", i, q_obs[i]);
      end
    end
  endtask

  task automatic test_line0;
    q_obs.delete(); q_exp.delete();
    tick(0, 1, 0, 0, 0);
    blank(3);
    px(400, 45);
    blank(6);
    for (int i = 0; i < 22; i++) begin
      tests++;
      if (q_obs[4+i].addr !== 9'(i % TW)) begin
        fails++;
        $display("FAIL line0_seq i=%0d got=%0d exp=%0d", i, q_obs[4+i].addr, i % TW);
      end
    end
    for (int i = 0; i < q_obs.size(); i++) begin
      tests++;
      if (q_obs[i] !== q_exp[i]) begin
        fails++;
        $display("FAIL line0_model i=%0d got=%h exp=%h", i, q_obs[i], q_exp[i]);
      end
    end
  endtask

  task automatic test_scroll;
    q_obs.delete(); q_exp.delete();
    tick(1, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      tick(0, 1, 1, 0, 0);
      tick(0, 0, 1, 0, 0);
      tests++;
      if (q_obs[q_obs.size()-2].scr !== 5'(((k + 1) * STEP) % TW)) begin
        fails++;
        $display("FAIL scroll_step k=%0d got=%0d exp=%0d", k,
                 q_obs[q_obs.size()-2].scr, ((k + 1) * STEP) % TW);
      end
      tests++;
      if (q_obs[q_obs.size()-1].scr !== 5'(((k + 1) * STEP) % TW)) begin
        fails++;
        $display("FAIL scroll_hold k=%0d got=%0d exp=%0d", k,
                 q_obs[q_obs.size()-1].scr, ((k + 1) * STEP) % TW);
      end
    end
    tick(0, 1, 1, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tests++;
    if (q_obs[q_obs.size()-1].scr !== 5'(STEP)) begin
      fails++;
      $display("FAIL scroll_frozen got=%0d exp=%0d", q_obs[q_obs.size()-1].scr, STEP);
    end
    for (int i = 0; i < q_obs.size(); i++) begin
      tests++;
      if (q_obs[i] !== q_exp[i]) begin
        fails++;
        $display("FAIL scroll_model i=%0d got=%h exp=%h", i, q_obs[i], q_exp[i]);
      end
    end
  endtask

  task automatic test_row3;
    int p3, p4;
    int want[4];
    want = '{78, 79, 60, 61};
    q_obs.delete(); q_exp.delete();
    tick(1, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) tick(0, 1, 1, 0, 0);
    tick(0, 1, 0, 0, 0);
    blank(2);
    for (int y = 400; y < 403; y++) begin px(y, 20); blank(4); end
    p3 = q_obs.size();
    px(403, 20); blank(4);
    p4 = q_obs.size();
    px(404, 3); blank(4);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (q_obs[p3+i].addr !== 9'(want[i])) begin
        fails++;
        $display("FAIL row3_addr i=%0d got=%0d exp=%0d", i, q_obs[p3+i].addr, want[i]);
      end
    end
    tests++;
    if (q_obs[p4].addr !== 9'd98) begin
      fails++;
      $display("FAIL row4_base got=%0d exp=98", q_obs[p4].addr);
    end
    for (int i = 0; i < q_obs.size(); i++) begin
      tests++;
      if (q_obs[i] !== q_exp[i]) begin
        fails++;
        $display("FAIL row3_model i=%0d got=%h exp=%h", i, q_obs[i], q_exp[i]);
      end
    end
  endtask

  task automatic test_outside;
    q_obs.delete(); q_exp.delete();
    tick(0, 1, 0, 0, 0);
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 30; i++) tick(0, 0, 0, 1'($urandom_range(0, 3) != 0), (l % 2) ? 420 : 399);
      blank(3);
    end
    for (int i = 0; i < q_obs.size(); i++) begin
      tests++;
      if (q_obs[i].addr !== 9'd0 || q_obs[i].pix !== 8'd0 || q_obs[i].opq !== 1'b0) begin
        fails++;
        $display("FAIL outside_zero i=%0d got=%h", i, q_obs[i]);
      end
      tests++;
      if (q_obs[i].de !== q_exp[i].de) begin
        fails++;
        $display("FAIL outside_de i=%0d got=%b exp=%b", i, q_obs[i].de, q_exp[i].de);
      end
    end
  endtask

  task automatic test_transparent;
    int p, cnt;
    q_obs.delete(); q_exp.delete();
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    blank(2);
    p = q_obs.size();
    px(400, 20);
    blank(4);
    cnt = 0;
    for (int i = 0; i < q_obs.size(); i++)
      if (q_obs[i].de === 1'b1 && q_obs[i].opq === 1'b0) cnt++;
    tests++;
    if (cnt != 1) begin
      fails++;
      $display("FAIL transp_count got=%0d exp=1", cnt);
    end
    tests++;
    if (q_obs[p+7].opq !== 1'b0 || q_obs[p+6].opq !== 1'b1 || q_obs[p+8].opq !== 1'b1) begin
      fails++;
      $display("FAIL transp_pixel got=%b%b%b exp=101",
               q_obs[p+6].opq, q_obs[p+7].opq, q_obs[p+8].opq);
    end
    for (int i = 0; i < q_obs.size(); i++) begin
      tests++;
      if (q_obs[i] !== q_exp[i]) begin
        fails++;
        $display("FAIL transp_model i=%0d got=%h exp=%h", i, q_obs[i], q_exp[i]);
      end
    end
  endtask

  task automatic test_reset_midline;
    int pr, pn;
    q_obs.delete(); q_exp.delete();
    tick(0, 1, 1, 0, 0);
    tick(0, 1, 1, 0, 0);
    blank(2);
    px(400, 10);
    pr = q_obs.size();
    tick(1, 0, 0, 1, 400);
    px(400, 8);
    blank(4);
    tick(0, 1, 0, 0, 0);
    blank(2);
    pn = q_obs.size();
    px(400, 5);
    blank(4);
    tests++;
    if (q_obs[pr] !== smp_t'(0)) begin
      fails++;
      $display("FAIL midrst_zero got=%h exp=0", q_obs[pr]);
    end
    tests++;
    if (q_obs[pn].addr !== 9'd0 || q_obs[pn+1].addr !== 9'd1) begin
      fails++;
      $display("FAIL midrst_restart got=%0d,%0d exp=0,1", q_obs[pn].addr, q_obs[pn+1].addr);
    end
    for (int i = 0; i < q_obs.size(); i++) begin
      tests++;
      if (q_obs[i] !== q_exp[i]) begin
        fails++;
        $display("FAIL midrst_model i=%0d got=%h exp=%h", i, q_obs[i], q_exp[i]);
      end
    end
  endtask

  task automatic test_random;
    bit rn, conc, fsb, gap;
    int y0, n;
    q_obs.delete(); q_exp.delete();
    tick(1, 0, 0, 0, 0);
    for (int f = 0; f < 5; f++) begin
      rn   = 1'($urandom_range(0, 3) != 0);
      conc = 1'($urandom_range(0, 1));
      y0   = $urandom_range(0, 1) ? 398 : 400;
      if (!conc) begin tick(0, 1, rn, 0, 0); blank(2); end
      for (int l = 0; l < 24; l++) begin
        n = $urandom_range(15, 45);
        for (int p = 0; p < n; p++) begin
          fsb = conc && (l == 0) && (p == 0);
          gap = (p > 0) && ($urandom_range(0, 24) == 0);
          tick(0, fsb, rn, !gap, y0 + l);
        end
        blank($urandom_range(2, 6));
      end
    end
    for (int i = 0; i < q_obs.size(); i++) begin
      tests++;
      if (q_obs[i] !== q_exp[i]) begin
        fails++;
        $display("FAIL random_model i=%0d got=%h exp=%h", i, q_obs[i], q_exp[i]);
      end
    end
  endtask

  initial begin
    rsta = 1'b1; frame_start = 1'b0; run = 1'b0; pix_de = 1'b0;
    pix_y = '0; pix_x = '0;
    cyc = 0; m_scroll = 0; m_rows = 0; m_s0 = 0; m_n = 0;
    m_prev_de = 0; m_prev_strip = 0;
    for (int i = 0; i < 512; i++) rom[i] = 8'($urandom_range(1, 255));
    rom[5] = TR;
    test_reset;
    test_line0;
    test_scroll;
    test_row3;
    test_outside;
    test_transparent;
    test_reset_midline;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grass_fetch.md
# grass_fetch

Read-side engine for the 400x8 grass tile ROM (20x20 pixels, row-major, 8-bit colour, one-cycle synchronous read, no output register). It turns the VGA pixel stream into ROM addresses for a horizontally scrolling ground strip. It absorbs the ROM read latency and delivers an aligned colour, valid and opaque flag to the pixel mixer. Scroll advances once per frame while the game runs.

## Interface
Parameters:
- TILE_W, 20, tile width in pixels
- TILE_H, 20, tile height in pixels; TILE_W*TILE_H must not exceed 512
- STRIP_Y0, 400, first screen row of the grass strip
- SCROLL_STEP, 2, pixels scrolled per frame; must be in 1..TILE_W-1
- TRANSP, 8'h00, colour key treated as transparent

Ports (one clock; reset is synchronous and active-high):
- clka  in  1  pixel clock
- rsta  in  1  synchronous active-high reset
- pix_x  in  10  current pixel column; used for debug compare only
- pix_y  in  10  current pixel row
- pix_de  in  1  active-video enable
- frame_start  in  1  one-cycle pulse, nominally in vertical blanking
- run  in  1  game running; scroll is frozen when low
- rom_addr  out  9  registered address to ROM addra
- rom_data  in  8  ROM doa
- pix_out  out  8  colour aligned to pix_out_de
- pix_out_de  out  1  pix_de delayed 2 cycles
- pix_opaque  out  1  in strip, delayed, and rom_data != TRANSP
- scroll  out  5  current scroll offset, 0..TILE_W-1

## Operation
- Scroll counter: on frame_start with run=1, scroll <= scroll+SCROLL_STEP, minus TILE_W if the sum is >= TILE_W. With run=0 it holds.
- Strip membership: in_strip = pix_de && STRIP_Y0 <= pix_y < STRIP_Y0+TILE_H.
- Row base accumulator row_base (9 bit) equals the current strip row times TILE_W, with no multiplier.
  - Cleared on frame_start.
  - On the pix_de falling edge (de_d=1, pix_de=0) of a line that was in the strip: row_base += TILE_W, saturating at (TILE_H-1)*TILE_W.
- Column counter col (0..TILE_W-1) per active pixel:
  - col_eff = scroll on the first pixel of a line (pix_de=1, de_d=0); otherwise col_eff = col.
  - col <= col_eff+1, wrapping TILE_W-1 -> 0.
- Address: rom_addr <= in_strip ? row_base+col_eff : 0.
- Output stage: pix_out <= strip_d2 ? rom_data : 0. pix_opaque <= strip_d2 && rom_data != TRANSP.
- Simultaneous frame_start and pix_de: frame_start updates scroll and row_base first. The pixel uses the new scroll.
- Reset mid-line: every register clears. The remainder of that line is treated as starting with col=0 until the next de rising edge.

## Timing
- Reset values: rom_addr=0, pix_out=0, pix_out_de=0, pix_opaque=0, scroll=0. Internal col, row_base, de_d and strip pipeline are all 0.
- Input sampled at edge k -> rom_addr valid after k -> ROM samples at k+1 -> pix_out/pix_out_de/pix_opaque valid after k+2. Fixed latency is 2 cycles and is not stallable.
- pix_out_de mirrors pix_de exactly, 2 cycles late, including outside the strip.
- The scroll output changes the cycle after frame_start. It is stable for the whole frame.

## Structure
- grass_pkg holds TILE_W, TILE_H, ROM_DEPTH=400, TRANSP, and the address width constant (9). The ROM wrapper and this block share it.
- One natural sub-module is grass_scroll_ctr, the modulo-TILE_W accumulator with enable. The top level holds col/row logic and the 2-stage alignment pipe.

## Test plan
- Reset, then a line at pix_y=400 with scroll=0 -> rom_addr sequence 0,1,..,19,0,1,.. and pix_out equals the ROM model with 2-cycle lag. Outputs are 0 during reset.
- 5 frame_start pulses with run=1 -> scroll 2,4,6,8,10. After 10 pulses -> scroll=0 (wrap). With run=0, scroll holds.
- scroll=18, strip row 3 -> first addresses 78,79,60,61. pix_de falling edge -> row_base 80 for row 4.
- pix_y=399 and pix_y=420 -> rom_addr=0, pix_opaque=0, pix_out=0. pix_out_de still follows pix_de with 2-cycle lag.
- ROM model returns 8'h00 at one address -> pix_opaque=0 for exactly that pixel. Neighbouring pixels stay 1.
- rsta asserted mid-strip for 1 cycle -> next cycle all outputs 0. Next frame_start plus line 400 -> addresses restart at 0+scroll(=0).
